// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_pkg
//  Description : Shared opcodes, FSM state encoding, forwarding-select codes
//                and decode helpers for the hazard/flush controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_ctrl_pkg;

    // RV32I major opcodes seen by the decode stage
    localparam logic [6:0] OPCODE_R     = 7'b0110011;
    localparam logic [6:0] OPCODE_I     = 7'b0010011;
    localparam logic [6:0] OPCODE_LUI   = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC = 7'b0010111;
    localparam logic [6:0] OPCODE_L     = 7'b0000011;
    localparam logic [6:0] OPCODE_S     = 7'b0100011;
    localparam logic [6:0] OPCODE_B     = 7'b1100011;
    localparam logic [6:0] OPCODE_JAL   = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR  = 7'b1100111;

    // Controller state, visible on hazard_state
    typedef enum logic [1:0] {
        HZ_STATE_RUN   = 2'b00,
        HZ_STATE_STALL = 2'b01,
        HZ_STATE_FLUSH = 2'b10
    } hz_state_t;

    // EX operand mux selects
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // What an opcode does with the register file
    typedef struct packed {
        logic writes;
        logic use_rs1;
        logic use_rs2;
        logic is_load;
    } dec_info_t;

    function automatic dec_info_t decode_opcode(input logic [6:0] opcode);
        dec_info_t info;
        info = '0;
        case (opcode)
            OPCODE_R:     begin info.writes = 1'b1; info.use_rs1 = 1'b1; info.use_rs2 = 1'b1; end
            OPCODE_I:     begin info.writes = 1'b1; info.use_rs1 = 1'b1; end
            OPCODE_LUI:   begin info.writes = 1'b1; end
            OPCODE_AUIPC: begin info.writes = 1'b1; end
            OPCODE_L:     begin info.writes = 1'b1; info.use_rs1 = 1'b1; info.is_load = 1'b1; end
            OPCODE_S:     begin info.use_rs1 = 1'b1; info.use_rs2 = 1'b1; end
            OPCODE_B:     begin info.use_rs1 = 1'b1; info.use_rs2 = 1'b1; end
            OPCODE_JAL:   begin info.writes = 1'b1; end
            OPCODE_JALR:  begin info.writes = 1'b1; info.use_rs1 = 1'b1; end
            default:      info = '0;
        endcase
        return info;
    endfunction

    // The youngest in-flight producer wins: EX writer goes to MEM next, MEM writer to WB
    function automatic logic [1:0] fwd_select(input logic used,
                                              input logic ex_hit,
                                              input logic mem_hit);
        logic [1:0] sel;
        sel = FWD_RF;
        if (used && ex_hit) begin
            sel = FWD_MEM;
        end else if (used && mem_hit) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : Three-entry shift of in-flight destinations {valid, rd,
//                is_load} for EX, MEM and WB, with per-stage source match
//                vectors (bit 0 = EX, bit 1 = MEM, bit 2 = WB).
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int XLEN_RF = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_advance,
    input  logic               i_bubble,
    input  logic               i_id_writes,
    input  logic [XLEN_RF-1:0] i_id_rd,
    input  logic               i_id_is_load,
    input  logic [XLEN_RF-1:0] i_rs1,
    input  logic [XLEN_RF-1:0] i_rs2,
    output logic [2:0]         o_rs1_match,
    output logic [2:0]         o_rs2_match,
    output logic [2:0]         o_is_load
);

    logic [2:0]         r_valid;
    logic [2:0]         r_is_load;
    logic [XLEN_RF-1:0] r_rd [3];
    logic               w_push;

    // x0 is never tracked; a bubble or flush inserts an empty EX entry
    assign w_push = i_advance && !i_bubble && i_id_writes && (i_id_rd != '0);

    // Shift the scoreboard one stage per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= '0;
            r_is_load <= '0;
            for (int i = 0; i < 3; i++) begin
                r_rd[i] <= '0;
            end
        end else begin
            r_valid   <= {r_valid[1:0], w_push};
            r_is_load <= {r_is_load[1:0], w_push && i_id_is_load};
            r_rd[2]   <= r_rd[1];
            r_rd[1]   <= r_rd[0];
            r_rd[0]   <= w_push ? i_id_rd : '0;
        end
    end

    generate
        for (genvar g = 0; g < 3; g++) begin : g_stage
            assign o_rs1_match[g] = r_valid[g] && (r_rd[g] == i_rs1);
            assign o_rs2_match[g] = r_valid[g] && (r_rd[g] == i_rs2);
        end
    endgenerate

    assign o_is_load = r_is_load;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Hazard and flush controller for the 5-stage pipeline.
//                Produces IF/ID and ID/EX stall, bubble and flush controls
//                plus registered EX operand forwarding selects.
//                Build option HAZARD_FORWARDING_EN: when defined, forwarding
//                is active and only load-use stalls; when undefined, selects
//                are tied to the regfile and any EX/MEM producer stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int XLEN_RF   = 5,
    parameter int MAX_STALL = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [6:0]         id_opcode,
    input  logic [XLEN_RF-1:0] id_rs1,
    input  logic [XLEN_RF-1:0] id_rs2,
    input  logic [XLEN_RF-1:0] id_rd,
    input  logic               id_flush,
    input  logic               ex_branch_taken,
    output logic               stall_if,
    output logic               stall_id,
    output logic               bubble_ex,
    output logic               flush_if_id,
    output logic               flush_id_ex,
    output logic [1:0]         fwd_a,
    output logic [1:0]         fwd_b,
    output logic [1:0]         hazard_state
);

    localparam int c_CNT_W = $clog2(MAX_STALL + 1);

    hz_state_t          r_state;
    hz_state_t          w_state_nxt;
    logic [c_CNT_W-1:0] r_stall_cnt;
    logic [c_CNT_W-1:0] w_stall_cnt_nxt;

    dec_info_t  w_dec;
    logic       w_id_ok;
    logic       w_use_rs1;
    logic       w_use_rs2;
    logic       w_hazard;
    logic       w_stall;
    logic       w_advance;
    logic       w_flush_if_id;
    logic       w_flush_id_ex;
    logic [2:0] w_rs1_match;
    logic [2:0] w_rs2_match;
    logic [2:0] w_load_flags;

    // The instruction in ID is ignored for the one cycle after a taken branch
    assign w_dec     = decode_opcode(id_opcode);
    assign w_id_ok   = id_valid && (r_state != HZ_STATE_FLUSH);
    assign w_use_rs1 = w_id_ok && w_dec.use_rs1 && (id_rs1 != '0);
    assign w_use_rs2 = w_id_ok && w_dec.use_rs2 && (id_rs2 != '0);

    hazard_scoreboard #(
        .XLEN_RF (XLEN_RF)
    ) u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_advance    (w_advance),
        .i_bubble     (w_stall || ex_branch_taken),
        .i_id_writes  (w_dec.writes),
        .i_id_rd      (id_rd),
        .i_id_is_load (w_dec.is_load),
        .i_rs1        (id_rs1),
        .i_rs2        (id_rs2),
        .o_rs1_match  (w_rs1_match),
        .o_rs2_match  (w_rs2_match),
        .o_is_load    (w_load_flags)
    );

`ifdef HAZARD_FORWARDING_EN
    logic [1:0] r_fwd_a;
    logic [1:0] r_fwd_b;
    logic       w_unused_sb;

    // Only a load still in EX cannot be forwarded in time
    assign w_hazard = (w_use_rs1 && w_rs1_match[0] && w_load_flags[0]) ||
                      (w_use_rs2 && w_rs2_match[0] && w_load_flags[0]);

    // Forwarding selects follow the instruction into EX; bubbles get regfile
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fwd_a <= FWD_RF;
            r_fwd_b <= FWD_RF;
        end else if (w_advance) begin
            r_fwd_a <= fwd_select(w_use_rs1, w_rs1_match[0], w_rs1_match[1]);
            r_fwd_b <= fwd_select(w_use_rs2, w_rs2_match[0], w_rs2_match[1]);
        end else begin
            r_fwd_a <= FWD_RF;
            r_fwd_b <= FWD_RF;
        end
    end

    assign fwd_a       = r_fwd_a;
    assign fwd_b       = r_fwd_b;
    assign w_unused_sb = ^{w_rs1_match[2], w_rs2_match[2], w_load_flags[2:1]};
`else
    logic w_unused_sb;

    // Without forwarding any producer still in EX or MEM must drain to WB
    assign w_hazard = (w_use_rs1 && (|w_rs1_match[1:0])) ||
                      (w_use_rs2 && (|w_rs2_match[1:0]));

    assign fwd_a       = FWD_RF;
    assign fwd_b       = FWD_RF;
    assign w_unused_sb = ^{w_rs1_match[2], w_rs2_match[2], w_load_flags};
`endif

    // State and stall-counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= HZ_STATE_RUN;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_stall_cnt <= w_stall_cnt_nxt;
        end
    end

    // Next state and controls: taken branch beats stall beats jump flush
    always_comb begin
        w_state_nxt     = r_state;
        w_stall_cnt_nxt = r_stall_cnt;
        w_stall         = 1'b0;
        w_advance       = 1'b0;
        w_flush_if_id   = 1'b0;
        w_flush_id_ex   = 1'b0;

        if (ex_branch_taken) begin
            w_flush_if_id   = 1'b1;
            w_flush_id_ex   = 1'b1;
            w_state_nxt     = HZ_STATE_FLUSH;
            w_stall_cnt_nxt = '0;
        end else if (w_hazard) begin
            w_stall     = 1'b1;
            w_state_nxt = HZ_STATE_STALL;
            if (r_state != HZ_STATE_STALL) begin
                w_stall_cnt_nxt = c_CNT_W'(1);
            end else if (r_stall_cnt != c_CNT_W'(MAX_STALL)) begin
                w_stall_cnt_nxt = r_stall_cnt + c_CNT_W'(1);
            end
        end else begin
            // RUN, FLUSH ending, or a stall that has just cleared
            w_state_nxt     = HZ_STATE_RUN;
            w_stall_cnt_nxt = '0;
            w_advance       = w_id_ok;
            w_flush_if_id   = w_id_ok && id_flush;
        end
    end

    // Controls are forced low for as long as reset is held
    assign stall_if     = rst_n && w_stall;
    assign stall_id     = rst_n && w_stall;
    assign bubble_ex    = rst_n && w_stall;
    assign flush_if_id  = rst_n && w_flush_if_id;
    assign flush_id_ex  = rst_n && w_flush_id_ex;
    assign hazard_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl: directed scenarios and
//                randomized instruction streams against an age-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

`ifdef HAZARD_FORWARDING_EN
    localparam int         LU_STALLS  = 1;
    localparam int         ALU_STALLS = 0;
    localparam logic [1:0] LU_FWD     = 2'b10;
    localparam logic [1:0] ALU_FWD    = 2'b01;
`else
    localparam int         LU_STALLS  = 2;
    localparam int         ALU_STALLS = 2;
    localparam logic [1:0] LU_FWD     = 2'b00;
    localparam logic [1:0] ALU_FWD    = 2'b00;
`endif

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] id_rd;
    logic       id_flush;
    logic       ex_branch_taken;
    logic       stall_if;
    logic       stall_id;
    logic       bubble_ex;
    logic       flush_if_id;
    logic       flush_id_ex;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic [1:0] hazard_state;

    hazard_ctrl #(
        .XLEN_RF   (5),
        .MAX_STALL (2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_opcode       (id_opcode),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rd           (id_rd),
        .id_flush        (id_flush),
        .ex_branch_taken (ex_branch_taken),
        .stall_if        (stall_if),
        .stall_id        (stall_id),
        .bubble_ex       (bubble_ex),
        .flush_if_id     (flush_if_id),
        .flush_id_ex     (flush_id_ex),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .hazard_state    (hazard_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Model: list of what entered EX, newest first (age 0 = EX, age 1 = MEM)
    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       ld;
    } rec_t;

    rec_t       hist[$];
    int         m_state;
    logic [1:0] m_fwd_a;
    logic [1:0] m_fwd_b;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void tb_decode(input logic [6:0] op, output bit wr, output bit u1,
                                      output bit u2, output bit ld);
        wr = op inside {OP_R, OP_I, OP_LUI, OP_AUIPC, OP_L, OP_JAL, OP_JALR};
        u1 = op inside {OP_R, OP_S, OP_B, OP_I, OP_L, OP_JALR};
        u2 = op inside {OP_R, OP_S, OP_B};
        ld = (op == OP_L);
    endfunction

    function automatic bit hits(input rec_t r, input logic [4:0] rs);
        return r.v && (rs != 5'd0) && (r.rd == rs);
    endfunction

    function automatic logic [1:0] want_fwd(input bit adv, input bit used, input rec_t ex,
                                            input rec_t mem, input logic [4:0] rs);
`ifdef HAZARD_FORWARDING_EN
        if (!adv || !used) return 2'b00;
        if (hits(ex, rs))  return 2'b01;
        if (hits(mem, rs)) return 2'b10;
        return 2'b00;
`else
        return 2'b00 & {2{adv & used & (rs != 5'd0) & ex.v & mem.v}};
`endif
    endfunction

    task automatic model_reset();
        hist.delete();
        m_state = 0;
        m_fwd_a = 2'b00;
        m_fwd_b = 2'b00;
    endtask

    // One cycle: drive ID, compare all outputs, then advance the model at the edge
    task automatic step(input bit v, input logic [6:0] op, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [4:0] rd, input bit jf,
                        input bit br, output bit stalled);
        bit         wr, u1, u2, ld, id_ok, haz, adv;
        rec_t       ex, mem, nr;
        logic [1:0] na, nb;
        ex  = '{v: 1'b0, rd: 5'd0, ld: 1'b0};
        mem = ex;
        #1;
        id_valid        = v;
        id_opcode       = op;
        id_rs1          = r1;
        id_rs2          = r2;
        id_rd           = rd;
        id_flush        = jf;
        ex_branch_taken = br;
        #1;
        tb_decode(op, wr, u1, u2, ld);
        if (hist.size() > 0) ex  = hist[0];
        if (hist.size() > 1) mem = hist[1];
        id_ok = v && (m_state != 2);
        u1    = u1 && id_ok;
        u2    = u2 && id_ok;
`ifdef HAZARD_FORWARDING_EN
        haz = (u1 && ex.ld && hits(ex, r1)) || (u2 && ex.ld && hits(ex, r2));
`else
        haz = (u1 && (hits(ex, r1) || hits(mem, r1))) || (u2 && (hits(ex, r2) || hits(mem, r2)));
`endif
        haz = haz && !br;
        adv = id_ok && !br && !haz;
        check_val("state", hazard_state, m_state);
        check_val("fwd_a", fwd_a, m_fwd_a);
        check_val("fwd_b", fwd_b, m_fwd_b);
        check_val("stall_if", stall_if, haz);
        check_val("stall_id", stall_id, haz);
        check_val("bubble_ex", bubble_ex, haz);
        check_val("flush_if_id", flush_if_id, br || (adv && jf));
        check_val("flush_id_ex", flush_id_ex, br);
        nr = '{v: adv && wr && (rd != 5'd0), rd: rd, ld: ld};
        na = want_fwd(adv, u1, ex, mem, r1);
        nb = want_fwd(adv, u2, ex, mem, r2);
        stalled = haz;
        @(posedge clk);
        hist.push_front(nr);
        if (hist.size() > 2) void'(hist.pop_back());
        m_fwd_a = na;
        m_fwd_b = nb;
        m_state = br ? 2 : (haz ? 1 : 0);
    endtask

    // Present one instruction until it leaves ID; returns the stall cycles seen
    task automatic run_instr(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                             input logic [4:0] rd, input bit jf, output int nst);
        bit s;
        nst = 0;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, op, r1, r2, rd, jf, 1'b0, s);
            if (!s) break;
            nst++;
        end
    endtask

    task automatic idle(input int n);
        bit s;
        for (int k = 0; k < n; k++) step(1'b0, OP_I, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, s);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0] ops [9];
        int         nst;
        bit         s;
        bit         cv, cj, br;
        logic [6:0] cop;
        logic [4:0] c1, c2, cd;

        ops = '{OP_R, OP_I, OP_LUI, OP_AUIPC, OP_L, OP_S, OP_B, OP_JAL, OP_JALR};
        rst_n = 1'b0;
        id_valid = 1'b0; id_opcode = OP_I; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_flush = 1'b0; ex_branch_taken = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_state", hazard_state, 2'b00);
        check_val("rst_fwd_a", fwd_a, 2'b00);
        check_val("rst_fwd_b", fwd_b, 2'b00);
        rst_n = 1'b1;
        @(posedge clk);

        // Back-to-back ALU dependency
        run_instr(OP_I, 5'd0, 5'd0, 5'd3, 1'b0, nst);
        run_instr(OP_R, 5'd3, 5'd3, 5'd4, 1'b0, nst);
        check_val("alu_stalls", nst, ALU_STALLS);
        #1;
        check_val("alu_fwd_a", fwd_a, ALU_FWD);
        check_val("alu_fwd_b", fwd_b, ALU_FWD);
        idle(3);

        // Load-use
        run_instr(OP_L, 5'd1, 5'd0, 5'd5, 1'b0, nst);
        run_instr(OP_R, 5'd5, 5'd2, 5'd6, 1'b0, nst);
        check_val("lu_stalls", nst, LU_STALLS);
        #1;
        check_val("lu_fwd_a", fwd_a, LU_FWD);
        check_val("lu_fwd_b", fwd_b, 2'b00);
        idle(3);

        // x0 destination and stores never create a dependency
        run_instr(OP_L, 5'd1, 5'd0, 5'd0, 1'b0, nst);
        run_instr(OP_R, 5'd0, 5'd0, 5'd1, 1'b0, nst);
        check_val("x0_stalls", nst, 0);
        idle(3);
        run_instr(OP_S, 5'd1, 5'd5, 5'd5, 1'b0, nst);
        run_instr(OP_R, 5'd5, 5'd0, 5'd6, 1'b0, nst);
        check_val("sw_stalls", nst, 0);
        idle(3);

        // Taken branch while a load-use hazard sits in ID
        run_instr(OP_L, 5'd1, 5'd0, 5'd5, 1'b0, nst);
        step(1'b1, OP_R, 5'd5, 5'd2, 5'd6, 1'b0, 1'b1, s);
        #1;
        check_val("br_state_flush", hazard_state, 2'b10);
        step(1'b1, OP_R, 5'd5, 5'd2, 5'd6, 1'b0, 1'b0, s);
        #1;
        check_val("br_state_run", hazard_state, 2'b00);
        idle(3);

        // Jumps: free-running, and held behind a load-use stall
        run_instr(OP_JAL, 5'd0, 5'd0, 5'd1, 1'b1, nst);
        run_instr(OP_L, 5'd2, 5'd0, 5'd7, 1'b0, nst);
        run_instr(OP_JALR, 5'd7, 5'd0, 5'd1, 1'b1, nst);
        check_val("jalr_stalls", nst, LU_STALLS);
        idle(3);

        // Asynchronous reset while stalled, with a branch pending
        run_instr(OP_L, 5'd1, 5'd0, 5'd5, 1'b0, nst);
        step(1'b1, OP_R, 5'd5, 5'd2, 5'd6, 1'b0, 1'b0, s);
        #1;
        check_val("pre_rst_state", hazard_state, 2'b01);
        rst_n = 1'b0;
        ex_branch_taken = 1'b1;
        #1;
        check_val("mid_rst_state", hazard_state, 2'b00);
        check_val("mid_rst_stall_if", stall_if, 1'b0);
        check_val("mid_rst_bubble", bubble_ex, 1'b0);
        check_val("mid_rst_flush_if_id", flush_if_id, 1'b0);
        check_val("mid_rst_flush_id_ex", flush_id_ex, 1'b0);
        @(posedge clk);
        #1;
        check_val("held_rst_state", hazard_state, 2'b00);
        @(negedge clk);
        ex_branch_taken = 1'b0;
        id_valid = 1'b0;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check_val("post_rst_fwd_a", fwd_a, 2'b00);
        // The load before reset must be forgotten
        run_instr(OP_R, 5'd5, 5'd2, 5'd6, 1'b0, nst);
        check_val("post_rst_stalls", nst, 0);

        // Randomized streams; a stalled instruction stays in ID
        s = 1'b0;
        cv = 1'b0; cop = OP_I; c1 = '0; c2 = '0; cd = '0; cj = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (!s) begin
                cv  = ($urandom_range(0, 9) != 0);
                cop = ops[$urandom_range(0, 8)];
                c1  = 5'($urandom_range(0, 4));
                c2  = 5'($urandom_range(0, 4));
                cd  = 5'($urandom_range(0, 4));
                cj  = (cop == OP_JAL) || (cop == OP_JALR);
            end
            br = ($urandom_range(0, 11) == 0);
            step(cv, cop, c1, c2, cd, cj, br, s);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and flush controller for the 5-stage core (IF/ID/EX/MEM/WB).
- Consumes decoded fields from the decode stage and keeps a registered scoreboard of in-flight destination registers for EX, MEM and WB.
- Produces stall, bubble, flush and forwarding-select controls that sequence the IF/ID and ID/EX pipeline registers.
- Sits beside decode; its outputs drive the pipeline-register enables and the EX operand muxes.

Parameters:
- XLEN_RF, 5, register-index width.
- MAX_STALL, 2, saturating limit of the stall counter; sized for the no-forwarding worst case.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a valid instruction.
- id_opcode  in  7  opcode of the ID instruction.
- id_rs1  in  5  source register 1.
- id_rs2  in  5  source register 2.
- id_rd  in  5  destination register.
- id_flush  in  1  jump (JAL/JALR) detected in ID.
- ex_branch_taken  in  1  branch resolved taken in EX this cycle.
- stall_if  out  1  hold PC and IF/ID.
- stall_id  out  1  hold the ID instruction.
- bubble_ex  out  1  load NOP into ID/EX.
- flush_if_id  out  1  clear IF/ID.
- flush_id_ex  out  1  clear ID/EX.
- fwd_a  out  2  EX operand-A select: 00 regfile, 01 MEM result, 10 WB result.
- fwd_b  out  2  EX operand-B select, same encoding as fwd_a.
- hazard_state  out  2  FSM state: 00 RUN, 01 STALL, 10 FLUSH.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=RUN, stall counter=0.
  - All scoreboard entries invalid.
  - fwd_a=fwd_b=00.
  - All stall, bubble and flush outputs are 0, combinationally while in reset.
- Writer opcodes: R, I, LUI, AUIPC, L, JAL, JALR. S and B never write. rd=x0 is never tracked.
- Source use:
  - R, S, B use rs1 and rs2.
  - I, L, JALR use rs1 only.
  - LUI, AUIPC, JAL use none.
- Scoreboard entry: {valid, rd, is_load}. Each cycle: WB<=MEM, MEM<=EX.
  - EX<=ID entry on a normal advance.
  - EX<=invalid on bubble or flush.
- Hazard (combinational on ID and scoreboard), with FORWARDING_EN defined: used source equals a load's rd in EX.
- FSM:
  - RUN: on hazard, assert stall_if, stall_id and bubble_ex; go to STALL with cnt=1.
  - STALL: re-evaluate the hazard every cycle, since the scoreboard keeps advancing.
    - Hazard persists: stay, cnt++ (saturates at MAX_STALL).
    - Hazard clears: outputs deassert in that same cycle, next state RUN, cnt=0.
  - Taken branch (any state): ex_branch_taken=1 asserts flush_if_id and flush_id_ex, with no stall and no bubble. Next state FLUSH.
  - FLUSH: lasts 1 cycle. ID is treated as invalid regardless of id_valid; return to RUN.
- Priority: ex_branch_taken > stall > id_flush.
  - id_flush in RUN with no hazard: flush_if_id=1 for one cycle; state stays RUN.
  - id_flush while stalled: ignored until the stall clears. The jump remains held in ID and re-asserts id_flush.
- Forwarding selects are registered, aligned to the instruction entering EX, and update only on a normal advance.
  - Bubble or flush: fwd_a and fwd_b load 00.
  - Per used source, rs matching the current EX writer -> 01; else matching the current MEM writer -> 10; else 00. The EX match wins.
  - rs=x0 always selects 00.
- Regfile writes in WB before reads in ID; no WB-stage hazard exists.
- Reset mid-stall or mid-flush: immediate return to RUN with the scoreboard cleared.

Optional Feature:
- HAZARD_FORWARDING_EN
- Defined:
  - Forwarding as above.
  - Only load-use stalls, at most 1 cycle.
- Undefined:
  - fwd_a and fwd_b are tied to 00.
  - Hazard = any used source matching a valid writer in EX or MEM; stalls last up to 2 cycles.
  - is_load is unused.

Decomposition:
- OPCODE_* constants come from define.vh.
- Add to define.vh:
  - HZ_STATE_RUN / HZ_STATE_STALL / HZ_STATE_FLUSH.
  - FWD_RF / FWD_MEM / FWD_WB.
  - The HAZARD_FORWARDING_EN guard.
- Sub-module hazard_scoreboard:
  - 3-entry shift of {valid, rd, is_load}.
  - Inputs: advance/bubble.
  - Outputs: per-stage match vectors for rs1 and rs2.

Test Plan:
- Reset: assert rst_n=0 mid-stall -> hazard_state=00, all outputs 0 the same cycle, fwd=00 after release.
- Load-use (forwarding): `lw x5,0(x1)` then `add x6,x5,x2` -> exactly 1 cycle of stall_if=stall_id=bubble_ex=1, then fwd_a=10 for the add in EX.
- Back-to-back ALU: `addi x3,x0,7` then `sub x4,x3,x3` -> no stall, fwd_a=fwd_b=01.
- No forwarding (macro undefined): `addi x3,...` then `add x4,x3,x0` -> 2 stall cycles, fwd=00 throughout.
- Branch over stall: ex_branch_taken=1 while a load-use hazard is present in ID -> flush_if_id=flush_id_ex=1, stall=0, next hazard_state=10, then 00.
- x0 and stores: `lw x0` then `add x1,x0,x0`, and `sw x5` with rd field 5 followed by `add x6,x5,x0` -> no stall in either case.
